sha256_iter: RTL and testbench

SHA256_ITER -- requirements
Module: sha256_iter

---
 rtl/sha256_iter.sv | 155 +++++++++++++++
 tb/tb_sha256_iter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_iter.sv
// SHA-256 iterative compression core.
// Unrolls ROUNDS_PER_CYCLE rounds per clock with an on-the-fly message schedule.
module sha256_iter #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [255:0] digest,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    localparam logic [5:0] LAST_CNT = 6'(64 - ROUNDS_PER_CYCLE);
    localparam logic [5:0] CNT_STEP = 6'(ROUNDS_PER_CYCLE);

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic        last_q;
    logic [31:0] h_q [8];
    logic [31:0] v_q [8];
    logic [31:0] w_q [16];
    logic [31:0] v_d [8];
    logic [31:0] w_d [16];

    // Chain of ROUNDS_PER_CYCLE rounds; window slot 0 always holds W_t.
    always_comb begin : rounds
        logic [31:0] t1;
        logic [31:0] t2;
        logic [31:0] wn;
        logic [5:0]  idx;
        t1  = '0;
        t2  = '0;
        wn  = '0;
        idx = '0;
        v_d = v_q;
        w_d = w_q;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            idx = cnt_q + 6'(j);
            t1  = v_d[7] + bsig1(v_d[4])
                + ((v_d[4] & v_d[5]) ^ (~v_d[4] & v_d[6]))
                + K[idx] + w_d[0];
            t2  = bsig0(v_d[0])
                + ((v_d[0] & v_d[1]) ^ (v_d[0] & v_d[2]) ^ (v_d[1] & v_d[2]));
            wn  = ssig1(w_d[14]) + w_d[9] + ssig0(w_d[1]) + w_d[0];
            for (int i = 0; i < 15; i++) w_d[i] = w_d[i+1];
            w_d[15] = wn;
            for (int i = 7; i > 0; i--) v_d[i] = v_d[i-1];
            v_d[4] = v_d[4] + t1;
            v_d[0] = t1 + t2;
        end
    end

    // Control FSM plus chaining, working and schedule registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            h_q     <= IV;
            for (int i = 0; i < 8; i++) v_q[i] <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (blk_valid) begin
                        for (int i = 0; i < 16; i++)
                            w_q[i] <= blk_data[511 - 32*i -: 32];
                        last_q  <= blk_last;
                        cnt_q   <= '0;
                        state_q <= ROUND;
                        if (blk_first) begin
                            h_q <= IV;
                            v_q <= IV;
                        end else begin
                            v_q <= h_q;
                        end
                    end
                end
                ROUND: begin
                    v_q   <= v_d;
                    w_q   <= w_d;
                    cnt_q <= cnt_q + CNT_STEP;
                    if (cnt_q == LAST_CNT) state_q <= FINAL;
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_q[i];
                    state_q <= last_q ? DONE : IDLE;
                end
                DONE: begin
                    if (dig_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign blk_ready = (state_q == IDLE);
    assign dig_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign digest    = {h_q[0], h_q[1], h_q[2], h_q[3],
                        h_q[4], h_q[5], h_q[6], h_q[7]};

endmodule

// File: tb/tb_sha256_iter.sv
// Bench for sha256_iter: four instances (1, 2, 4, 8 rounds per cycle)
// checked against known SHA-256 digests via an expected-digest queue.
module tb_sha256_iter;

    localparam logic [255:0] IV_DIG =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIG =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] EMPTY_DIG =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO_B1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] TWO_B2 = {448'h0, 32'h0, 32'h000001c0};

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [511:0] blk_data = '0;
    logic         blk_first = 1'b0;
    logic         blk_last = 1'b0;
    logic         vld [4];
    logic         rdy [4];
    logic         dv  [4];
    logic         dr  [4];
    logic         bsy [4];
    logic [255:0] dg  [4];

    logic [255:0] exp_q [$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sha256_iter #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .blk_valid (vld[g]),
            .blk_ready (rdy[g]),
            .blk_data  (blk_data),
            .blk_first (blk_first),
            .blk_last  (blk_last),
            .dig_valid (dv[g]),
            .dig_ready (dr[g]),
            .digest    (dg[g]),
            .busy      (bsy[g])
        );
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1);
    end

    // Offer one block to instance i and return after the transfer edge.
    task automatic xfer(input int i, input logic [511:0] d,
                        input logic f, input logic l);
        int k;
        k = 0;
        blk_data  = d;
        blk_first = f;
        blk_last  = l;
        vld[i]    = 1'b1;
        while (rdy[i] !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL xfer_timeout inst=%0d: blk_ready never 1", i);
        end
        @(negedge clk);
        vld[i] = 1'b0;
    endtask

    // Count negedges until dig_valid, scrambling idle inputs meanwhile.
    task automatic wait_dv(input int i, output int n);
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            for (int b = 0; b < 16; b++) blk_data[b*32 +: 32] = $urandom();
            blk_first = 1'($urandom());
            blk_last  = 1'($urandom());
            if (dv[i] === 1'b1) break;
        end
        if (n >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dv_timeout inst=%0d", i);
            n = -1;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rdy[i] !== 1'b1 || dv[i] !== 1'b0 || bsy[i] !== 1'b0
                || dg[i] !== IV_DIG) begin
                n_bad++;
                $display("FAIL reset inst=%0d: rdy=%b dv=%b busy=%b dig=%h",
                         i, rdy[i], dv[i], bsy[i], dg[i]);
            end
        end
    endtask

    task automatic test_abc();
        int n;
        logic [255:0] e;
        exp_q.push_back(ABC_DIG);
        xfer(0, ABC_BLK, 1'b1, 1'b1);
        n_cmp++;
        if (bsy[0] !== 1'b1 || rdy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL abc_busy: busy=%b rdy=%b, want 1 0", bsy[0], rdy[0]);
        end
        wait_dv(0, n);
        n_cmp++;
        if (n !== 65) begin
            n_bad++;
            $display("FAIL abc_latency: %0d edges, want 65", n);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (dg[0] !== e) begin
            n_bad++;
            $display("FAIL abc_digest: got %h want %h", dg[0], e);
        end
        @(negedge clk);
        n_cmp++;
        if (dv[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL abc_one_cycle: dv=%b rdy=%b, want 0 1", dv[0], rdy[0]);
        end
    endtask

    task automatic test_two_block();
        int n;
        bit seen;
        logic [255:0] e;
        exp_q.push_back(TWO_DIG);
        xfer(0, TWO_B1, 1'b1, 1'b0);
        n = 0;
        seen = 0;
        while (rdy[0] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
            blk_data  = ~blk_data ^ {16{32'($urandom())}};
            blk_first = ~blk_first;
            blk_last  = 1'b1;
            if (dv[0] === 1'b1) seen = 1;
        end
        n_cmp++;
        if (n !== 65 || seen) begin
            n_bad++;
            $display("FAIL two_gap: idle after %0d edges dv_seen=%0d, want 65 0",
                     n, seen);
        end
        xfer(0, TWO_B2, 1'b0, 1'b1);
        wait_dv(0, n);
        e = exp_q.pop_front();
        n_cmp++;
        if (dg[0] !== e) begin
            n_bad++;
            $display("FAIL two_digest: got %h want %h", dg[0], e);
        end
        @(negedge clk);
    endtask

    task automatic test_empty_all();
        int n;
        logic [255:0] e;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(EMPTY_DIG);
            xfer(i, EMPTY_BLK, 1'b1, 1'b1);
            wait_dv(i, n);
            n_cmp++;
            if (n !== (64 >> i) + 1) begin
                n_bad++;
                $display("FAIL empty_latency inst=%0d: %0d edges, want %0d",
                         i, n, (64 >> i) + 1);
            end
            e = exp_q.pop_front();
            n_cmp++;
            if (dg[i] !== e) begin
                n_bad++;
                $display("FAIL empty_digest inst=%0d: got %h want %h", i, dg[i], e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [255:0] e;
        dr[0] = 1'b0;
        exp_q.push_back(ABC_DIG);
        xfer(0, ABC_BLK, 1'b1, 1'b1);
        wait_dv(0, n);
        e = exp_q.pop_front();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dv[0] !== 1'b1 || dg[0] !== e || rdy[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold c=%0d: dv=%b rdy=%b dig=%h want 1 0 %h",
                         c, dv[0], rdy[0], dg[0], e);
            end
        end
        dr[0] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (dv[0] !== 1'b0 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release: dv=%b rdy=%b busy=%b, want 0 1 0",
                     dv[0], rdy[0], bsy[0]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [255:0] e;
        exp_q.push_back(ABC_DIG);
        xfer(0, ABC_BLK, 1'b1, 1'b1);
        repeat (30) @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        n_cmp++;
        if (rdy[0] !== 1'b1 || dv[0] !== 1'b0 || bsy[0] !== 1'b0
            || dg[0] !== IV_DIG) begin
            n_bad++;
            $display("FAIL mid_reset: rdy=%b dv=%b busy=%b dig=%h",
                     rdy[0], dv[0], bsy[0], dg[0]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(ABC_DIG);
        xfer(0, ABC_BLK, 1'b1, 1'b1);
        wait_dv(0, n);
        n_cmp++;
        if (n !== 65) begin
            n_bad++;
            $display("FAIL mid_reset_latency: %0d edges, want 65", n);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (dg[0] !== e) begin
            n_bad++;
            $display("FAIL mid_reset_digest: got %h want %h", dg[0], e);
        end
        @(negedge clk);
    endtask

    task automatic test_chain_from_reset();
        int n;
        logic [255:0] e;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(ABC_DIG);
        xfer(0, ABC_BLK, 1'b0, 1'b1);
        wait_dv(0, n);
        e = exp_q.pop_front();
        n_cmp++;
        if (dg[0] !== e) begin
            n_bad++;
            $display("FAIL chain_from_reset: got %h want %h", dg[0], e);
        end
        @(negedge clk);
    endtask

    task automatic test_first_after();
        int n;
        logic [255:0] e;
        exp_q.push_back(EMPTY_DIG);
        xfer(0, EMPTY_BLK, 1'b1, 1'b1);
        wait_dv(0, n);
        e = exp_q.pop_front();
        n_cmp++;
        if (dg[0] !== e) begin
            n_bad++;
            $display("FAIL first_after: got %h want %h", dg[0], e);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            vld[i] = 1'b0;
            dr[i]  = 1'b1;
        end
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        test_abc();
        test_two_block();
        test_empty_all();
        test_backpressure();
        test_reset_mid();
        test_chain_from_reset();
        test_first_after();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
